mul_ctrl: RTL and testbench
===========================

// Module: mul_ctrl
// PURPOSE
//  Sequential front/back end for the combinational 32x32 unsigned Wallace multiplier.
//  - Accepts multiply requests over a valid/ready handshake.
//  - Converts signed operands to magnitudes and drives the multiplier.
//  - Waits a fixed multicycle window, captures the 64-bit product and re-applies the sign.
//  - Returns a RISC-V style result (MUL/MULH/MULHSU/MULHU) over a second valid/ready handshake.
// PARAMETERS
//  MUL_CYCLES  2  cycles the multiplier output settles before capture; legal range >=1
//  TAG_W       5  width of the request tag carried through unchanged
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      request present
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  in_op      in   2      00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
//  in_a       in   32     multiplicand (rs1)
//  in_b       in   32     multiplier (rs2)
//  in_tag     in   TAG_W  request tag
//  flush      in   1      synchronous abort of any in-flight request
//  out_valid  out  1      result present; held until accepted
//  out_ready  in   1      consumer accepts result
//  out_res    out  32     MUL: product[31:0]; MULH*: product[63:32]
//  out_prod   out  64     full signed/unsigned 64-bit product per in_op
//  out_tag    out  TAG_W  tag of the request that produced out_res
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst=1):
//   - State goes to IDLE.
//   - out_valid=0, out_res=0, out_prod=0, out_tag=0, busy=0, in_ready=1.
//   - The counter and operand registers clear.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE: on in_valid&in_ready, capture the following and go to CALC:
//     - mag_a = (a_signed & in_a[31]) ? -in_a : in_a (32-bit; 0x8000_0000 stays 0x8000_0000).
//     - mag_b likewise.
//     - neg = (a_signed&in_a[31]) ^ (b_signed&in_b[31]).
//     - op, tag.
//     - cnt = MUL_CYCLES-1.
//     - a_signed = op in {01,10}; b_signed = op==01; MUL (00) uses unsigned magnitudes.
//   - CALC: the multiplier sees only the registered mag_a/mag_b.
//     - If cnt==0: prod_q <= mult_out and go to FIX.
//     - Otherwise cnt <= cnt-1.
//   - FIX: out_prod <= neg ? (~prod_q + 1) : prod_q (64-bit wrap).
//     - out_res is selected per op; out_tag <= tag; out_valid <= 1; go to DONE.
//   - DONE: out_valid=1; outputs are stable.
//     - If out_ready: out_valid <= 0 and go to IDLE.
//     - No new accept occurs in the same cycle; in_ready rises the cycle after the handshake.
//  Latency:
//   - Accept edge E0; out_valid is high after edge E(MUL_CYCLES+1).
//   - Throughput: one request per MUL_CYCLES+3 cycles with out_ready held high.
//  Boundaries:
//   - flush has priority over every transition: the state goes to IDLE next edge and out_valid <= 0.
//     - In DONE, the pending result is dropped even if out_ready=1 in the same cycle.
//     - flush in IDLE with in_valid=1 blocks the accept.
//   - rst mid-operation aborts immediately (async); no partial result appears.
//   - Zero operand with neg=1: -0 = 0, so the result is 0.
//   - Input changes while not in IDLE are ignored; results depend only on captured values.
//   - out_ready=1 outside DONE has no effect.
//   - Back-pressure: DONE may persist indefinitely; outputs are held bit-stable.
// STRUCTURE
//  - Shared package mul_pkg:
//    - op encodings OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU.
//    - state encodings S_IDLE/S_CALC/S_FIX/S_DONE.
//    - operand/product width constants.
//  - One sub-module: wallace (combinational 32x32 -> 64 unsigned), fed from mag_a/mag_b registers only.
//  - Everything else is flat in mul_ctrl: FSM, counter, sign logic, negate, result mux.
// TESTING
//  1. Reset mid-CALC (rst pulse async) -> busy=0, out_valid=0, in_ready=1 the same cycle; next request completes normally.
//  2. MULHU a=0xFFFF_FFFF b=0xFFFF_FFFF -> out_prod=0xFFFF_FFFE_0000_0001, out_res=0xFFFF_FFFE; out_valid after E(MUL_CYCLES+1).
//  3. MULH a=0x8000_0000 b=0x8000_0000 -> out_prod=0x4000_0000_0000_0000, out_res=0x4000_0000; MULH a=-3 b=7 -> out_res=0xFFFF_FFFF.
//  4. MULHSU a=0xFFFF_FFFF(-1) b=0xFFFF_FFFF -> out_prod=0xFFFF_FFFF_0000_0001, out_res=0xFFFF_FFFF; MUL a=-3 b=7 -> out_res=0xFFFF_FFEB.
//  5. Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid, out_res and out_tag held; in_ready=0; handshake then in_ready=1 next cycle.
//  6. Flush in CALC and in DONE with out_ready=1 -> no result handshake, tag never appears, IDLE next cycle.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op/state encodings and widths for the multiply controller
package mul_pkg;

  localparam int OPW   = 32;
  localparam int PRODW = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which the unsigned multiplier reads as 2^31.
  function automatic logic [OPW-1:0] magnitude(input logic [OPW-1:0] v, input logic sgn);
    return (sgn && v[OPW-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/wallace.sv
// rtl/wallace.sv - combinational 32x32 -> 64 unsigned multiplier, carry-save tree reduction
module wallace
  import mul_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] p
);

  logic [PRODW-1:0] rows [OPW];

  // Each level folds every group of three rows into sum/carry rows: 32->22->15->10->7->5->4->3->2.
  always_comb begin
    int n;
    int m;
    logic [PRODW-1:0] x;
    logic [PRODW-1:0] y;
    logic [PRODW-1:0] z;
    x = '0;
    y = '0;
    z = '0;
    for (int i = 0; i < OPW; i++) begin
      rows[i] = b[i] ? ({{(PRODW-OPW){1'b0}}, a} << i) : '0;
    end
    n = OPW;
    for (int lvl = 0; lvl < 8; lvl++) begin
      m = 0;
      for (int i = 0; i < OPW; i += 3) begin
        if (i + 2 < n) begin
          x = rows[i];
          y = rows[i+1];
          z = rows[i+2];
          rows[m]   = x ^ y ^ z;
          rows[m+1] = ((x & y) | (x & z) | (y & z)) << 1;
          m = m + 2;
        end else if (i < n) begin
          for (int j = i; j < n; j++) begin
            rows[m] = rows[j];
            m = m + 1;
          end
        end
      end
      n = m;
    end
    p = rows[0] + rows[1];
  end

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - request/response sequencer around the wallace multiplier with RISC-V sign handling
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [63:0]      out_prod,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OPW-1:0]   mag_a_q;
  logic [OPW-1:0]   mag_b_q;
  logic             neg_q;
  op_e              op_q;
  logic [TAG_W-1:0] tag_q;
  logic [PRODW-1:0] prod_q;
  logic [PRODW-1:0] mult_out;
  logic [PRODW-1:0] fixed;
  logic             a_signed;
  logic             b_signed;
  logic             accept;

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_ready && in_valid && !flush;
  assign a_signed = (op_e'(in_op) == OP_MULH) || (op_e'(in_op) == OP_MULHSU);
  assign b_signed = (op_e'(in_op) == OP_MULH);
  assign fixed    = neg_q ? (~prod_q + 64'd1) : prod_q;

  wallace u_wallace (
    .a (mag_a_q),
    .b (mag_b_q),
    .p (mult_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      op_q      <= OP_MUL;
      tag_q     <= '0;
      prod_q    <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mag_a_q <= magnitude(in_a, a_signed);
            mag_b_q <= magnitude(in_b, b_signed);
            neg_q   <= (a_signed & in_a[31]) ^ (b_signed & in_b[31]);
            op_q    <= op_e'(in_op);
            tag_q   <= in_tag;
            cnt_q   <= CNT_W'(MUL_CYCLES - 1);
          end
        end
        S_CALC: begin
          if (cnt_q == '0) prod_q <= mult_out;
          else             cnt_q  <= cnt_q - 1'b1;
        end
        S_FIX: begin
          if (!flush) begin
            out_prod  <= fixed;
            out_res   <= (op_q == OP_MUL) ? fixed[31:0] : fixed[63:32];
            out_tag   <= tag_q;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
      // A flushed result is dropped even when the consumer accepts it in the same cycle.
      if (flush) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - directed self-checking bench for mul_ctrl
module tb_mul_ctrl;

  localparam int MUL_CYCLES = 2;
  localparam int TAG_W      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [63:0]      out_prod;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_ctrl #(.MUL_CYCLES(MUL_CYCLES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_prod  (out_prod),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      step;
      k++;
    end
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    step;
    in_valid = 1'b0;
    in_op    = 2'b01;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h8765_4321;
    in_tag   = '1;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 20) begin
      step;
      k++;
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [TAG_W-1:0] tag,
                     input logic [63:0] exp_prod, input logic [31:0] exp_res);
    int k;
    issue(op, a, b, tag);
    wait_valid(k);
    chk({name, "_latency"}, 64'(k), 64'(MUL_CYCLES + 1));
    chk({name, "_prod"}, out_prod, exp_prod);
    chk({name, "_res"}, {32'd0, out_res}, {32'd0, exp_res});
    chk({name, "_tag"}, {59'd0, out_tag}, {59'd0, tag});
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int k;
    logic seen;
    logic [31:0] held_res;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) step;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_res", {32'd0, out_res}, 64'd0);
    chk("rst_out_prod", out_prod, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of CALC
    issue(2'b11, 32'd5, 32'd6, 5'h03);
    step;
    chk("mid_busy_before", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_partial", {63'd0, seen}, 64'd0);
    run("after_rst", 2'b11, 32'd5, 32'd6, 5'h04, 64'd30, 32'd0);

    run("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01,
        64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE);
    run("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'h02,
        64'h4000_0000_0000_0000, 32'h4000_0000);
    run("mulh_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 5'h05,
        64'hFFFF_FFFF_FFFF_FFEB, 32'hFFFF_FFFF);
    run("mulhsu_neg", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h06,
        64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF);
    run("mul_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 5'h07,
        64'h0000_0006_FFFF_FFEB, 32'hFFFF_FFEB);
    run("mulh_zero_neg", 2'b01, 32'd0, 32'hFFFF_FFFB, 5'h08, 64'd0, 32'd0);
    run("mulhu_shift", 2'b11, 32'h0001_0000, 32'h0001_0000, 5'h0B,
        64'h0000_0001_0000_0000, 32'h0000_0001);

    // out_ready held high from the start: accepted on the first DONE cycle
    out_ready = 1'b1;
    issue(2'b00, 32'd12, 32'd12, 5'h0C);
    wait_valid(k);
    chk("rdy_early_latency", 64'(k), 64'(MUL_CYCLES + 1));
    chk("rdy_early_res", {32'd0, out_res}, 64'd144);
    step;
    chk("rdy_early_drop", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // Back-pressure for 10 cycles in DONE
    issue(2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 5'h09);
    wait_valid(k);
    chk("bp_prod", out_prod, 64'h0000_0000_FFFE_0001);
    held_res = 32'hFFFE_0001;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_res", {32'd0, out_res}, {32'd0, held_res});
      chk("bp_tag", {59'd0, out_tag}, 64'h09);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
    chk("bp_valid_after", {63'd0, out_valid}, 64'd0);

    // Flush during CALC
    issue(2'b11, 32'd9, 32'd9, 5'h15);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_calc_busy", {63'd0, busy}, 64'd0);
    chk("flush_calc_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (out_valid || out_tag == 5'h15) seen = 1'b1;
    end
    chk("flush_calc_no_result", {63'd0, seen}, 64'd0);

    // Flush in DONE with out_ready high the same cycle
    issue(2'b11, 32'd2, 32'd3, 5'h0A);
    wait_valid(k);
    chk("flush_done_reach", {63'd0, out_valid}, 64'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    step;
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_done_busy", {63'd0, busy}, 64'd0);
    chk("flush_done_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush in IDLE blocks a concurrent request
    in_valid = 1'b1;
    flush    = 1'b1;
    step;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_idle_blocks", {63'd0, busy}, 64'd0);

    run("final", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 64'd1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
